// File: rtl/excp_pkg.sv
// Shared types and constants for the exception/interrupt commit sequencer.
// Holds the sequencer state enum, the CSR Ecode values and the bit positions
// of the per-cause flags carried on cmt_excp.
package excp_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned EXCP_W  = 6;
  localparam int unsigned ECODE_W = 6;
  localparam int unsigned ESUB_W  = 9;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REDIR = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Ecode values written to the CSR file
  localparam logic [ECODE_W-1:0] ECODE_INT  = 6'h00;
  localparam logic [ECODE_W-1:0] ECODE_ADEF = 6'h08;
  localparam logic [ECODE_W-1:0] ECODE_ALE  = 6'h09;
  localparam logic [ECODE_W-1:0] ECODE_SYS  = 6'h0B;
  localparam logic [ECODE_W-1:0] ECODE_BRK  = 6'h0C;
  localparam logic [ECODE_W-1:0] ECODE_INE  = 6'h0D;
  localparam logic [ECODE_W-1:0] ECODE_IPE  = 6'h0E;

  // Bit positions inside cmt_excp
  localparam int unsigned EXCP_ADEF = 0;
  localparam int unsigned EXCP_INE  = 1;
  localparam int unsigned EXCP_IPE  = 2;
  localparam int unsigned EXCP_SYS  = 3;
  localparam int unsigned EXCP_BRK  = 4;
  localparam int unsigned EXCP_ALE  = 5;

endpackage

// File: rtl/excp_prio_enc.sv
// Trap-event priority encoder (purely combinational).
// Picks the single highest-priority event of a committing instruction:
// INT > ADEF > INE > IPE > SYS > BRK > ALE > ERTN.
// Ports:
//   has_int   - pending enabled interrupt (used only with EXCP_CTRL_INT_EN)
//   cmt_excp  - per-cause exception flags
//   cmt_ertn  - instruction is ERTN
//   take      - some trap event is present
//   is_ertn   - the winning event is a trap return
//   ecode     - Ecode of the winning event
//   esubcode  - EsubCode of the winning event (always 0)
// Macro EXCP_CTRL_INT_EN: when defined, has_int takes part in selection.
module excp_prio_enc
  import excp_pkg::*;
(
  input  logic               has_int,
  input  logic [EXCP_W-1:0]  cmt_excp,
  input  logic               cmt_ertn,
  output logic               take,
  output logic               is_ertn,
  output logic [ECODE_W-1:0] ecode,
  output logic [ESUB_W-1:0]  esubcode
);

  logic int_hit;

`ifdef EXCP_CTRL_INT_EN
  assign int_hit = has_int;
`else
  // Interrupts disabled: the port is kept but deliberately unused.
  logic unused_has_int;
  assign unused_has_int = has_int;
  assign int_hit        = 1'b0;
`endif

  // Fixed-priority selection; ERTN only wins when nothing else is pending
  always_comb begin
    take     = int_hit | (|cmt_excp) | cmt_ertn;
    is_ertn  = 1'b0;
    ecode    = ECODE_INT;
    esubcode = '0;
    if (int_hit) begin
      ecode = ECODE_INT;
    end else if (cmt_excp[EXCP_ADEF]) begin
      ecode = ECODE_ADEF;
    end else if (cmt_excp[EXCP_INE]) begin
      ecode = ECODE_INE;
    end else if (cmt_excp[EXCP_IPE]) begin
      ecode = ECODE_IPE;
    end else if (cmt_excp[EXCP_SYS]) begin
      ecode = ECODE_SYS;
    end else if (cmt_excp[EXCP_BRK]) begin
      ecode = ECODE_BRK;
    end else if (cmt_excp[EXCP_ALE]) begin
      ecode = ECODE_ALE;
    end else if (cmt_ertn) begin
      is_ertn = 1'b1;
    end
  end

endmodule

// File: rtl/excp_ctrl.sv
// Exception/interrupt commit sequencer.
// Accepts one trap event per committing instruction, pulses the CSR flush
// (excp_flush or ertn_flush) together with pipe_flush, then offers the
// redirect PC to fetch over a valid/ready handshake and blocks commit for
// DRAIN_CYCLES further cycles before returning to IDLE.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   cmt_valid/pc/excp/ertn - committing instruction; cmt_ready accepts it
//   has_int               - pending enabled interrupt
//   eentry, era           - CSR EENTRY / ERA used as redirect targets
//   excp_flush/ertn_flush - one-cycle trap entry / return pulses
//   era_in/ecode_in/esubcode_in - values for the CSR, valid with excp_flush
//   pipe_flush            - kill younger in-flight instructions
//   redir_valid/pc/ready  - redirect handshake to fetch
// Macro EXCP_CTRL_INT_EN: enables interrupt-triggered traps.
module excp_ctrl
  import excp_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmt_valid,
  input  logic [XLEN-1:0]    cmt_pc,
  input  logic [EXCP_W-1:0]  cmt_excp,
  input  logic               cmt_ertn,
  output logic               cmt_ready,
  input  logic               has_int,
  input  logic [XLEN-1:0]    eentry,
  input  logic [XLEN-1:0]    era,
  output logic               excp_flush,
  output logic               ertn_flush,
  output logic [XLEN-1:0]    era_in,
  output logic [ECODE_W-1:0] ecode_in,
  output logic [ESUB_W-1:0]  esubcode_in,
  output logic               pipe_flush,
  output logic               redir_valid,
  output logic [XLEN-1:0]    redir_pc,
  input  logic               redir_ready
);

  logic               enc_take;
  logic               enc_is_ertn;
  logic [ECODE_W-1:0] enc_ecode;
  logic [ESUB_W-1:0]  enc_esub;

  state_e             state_q,       state_d;
  logic [CNT_W-1:0]   cnt_q,         cnt_d;
  logic               kind_ertn_q,   kind_ertn_d;
  logic [XLEN-1:0]    era_in_q,      era_in_d;
  logic [ECODE_W-1:0] ecode_q,       ecode_d;
  logic [ESUB_W-1:0]  esub_q,        esub_d;
  logic [XLEN-1:0]    redir_pc_q,    redir_pc_d;
  logic               cmt_ready_q,   cmt_ready_d;
  logic               excp_flush_q,  excp_flush_d;
  logic               ertn_flush_q,  ertn_flush_d;
  logic               pipe_flush_q,  pipe_flush_d;
  logic               redir_valid_q, redir_valid_d;

  excp_prio_enc u_prio_enc (
    .has_int  (has_int),
    .cmt_excp (cmt_excp),
    .cmt_ertn (cmt_ertn),
    .take     (enc_take),
    .is_ertn  (enc_is_ertn),
    .ecode    (enc_ecode),
    .esubcode (enc_esub)
  );

  // Next-state, latch and output decode; outputs are decoded from the next
  // state so every output leaves a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kind_ertn_d = kind_ertn_q;
    era_in_d    = era_in_q;
    ecode_d     = ecode_q;
    esub_d      = esub_q;
    redir_pc_d  = redir_pc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmt_valid && enc_take) begin
          kind_ertn_d = enc_is_ertn;
          era_in_d    = cmt_pc;
          ecode_d     = enc_ecode;
          esub_d      = enc_esub;
          state_d     = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        redir_pc_d = kind_ertn_q ? era : eentry;
        state_d    = ST_REDIR;
      end
      ST_REDIR: begin
        if (redir_ready) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYCLES);
          end
        end
      end
      ST_DRAIN: begin
        // Counter starts at DRAIN_CYCLES, so the last drain cycle sees 1
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmt_ready_d   = (state_d == ST_IDLE);
    pipe_flush_d  = (state_d == ST_FLUSH);
    excp_flush_d  = (state_d == ST_FLUSH) && !kind_ertn_d;
    ertn_flush_d  = (state_d == ST_FLUSH) &&  kind_ertn_d;
    redir_valid_d = (state_d == ST_REDIR);
  end

  // State, latched trap data and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      kind_ertn_q   <= 1'b0;
      era_in_q      <= '0;
      ecode_q       <= '0;
      esub_q        <= '0;
      redir_pc_q    <= '0;
      cmt_ready_q   <= 1'b1;
      excp_flush_q  <= 1'b0;
      ertn_flush_q  <= 1'b0;
      pipe_flush_q  <= 1'b0;
      redir_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      kind_ertn_q   <= kind_ertn_d;
      era_in_q      <= era_in_d;
      ecode_q       <= ecode_d;
      esub_q        <= esub_d;
      redir_pc_q    <= redir_pc_d;
      cmt_ready_q   <= cmt_ready_d;
      excp_flush_q  <= excp_flush_d;
      ertn_flush_q  <= ertn_flush_d;
      pipe_flush_q  <= pipe_flush_d;
      redir_valid_q <= redir_valid_d;
    end
  end

  assign cmt_ready   = cmt_ready_q;
  assign excp_flush  = excp_flush_q;
  assign ertn_flush  = ertn_flush_q;
  assign pipe_flush  = pipe_flush_q;
  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;
  assign era_in      = era_in_q;
  assign ecode_in    = ecode_q;
  assign esubcode_in = esub_q;

endmodule

// File: tb/tb_excp_ctrl.sv
// Self-checking bench for excp_ctrl: a timeline reference model predicts
// flush transactions, redirect targets and commit readiness; a monitor
// process pops and compares. A second instance with DRAIN_CYCLES=0 covers
// back-to-back trap acceptance.
module tb_excp_ctrl;

  localparam int unsigned DRAIN = 2;
`ifdef EXCP_CTRL_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        cmt_valid;
  logic [31:0] cmt_pc;
  logic [5:0]  cmt_excp;
  logic        cmt_ertn;
  logic        cmt_ready;
  logic        has_int;
  logic [31:0] eentry;
  logic [31:0] era;
  logic        excp_flush;
  logic        ertn_flush;
  logic [31:0] era_in;
  logic [5:0]  ecode_in;
  logic [8:0]  esubcode_in;
  logic        pipe_flush;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;

  logic        z_cmt_valid;
  logic [31:0] z_cmt_pc;
  logic [5:0]  z_cmt_excp;
  logic        z_cmt_ertn;
  logic        z_cmt_ready;
  logic        z_has_int;
  logic [31:0] z_eentry;
  logic [31:0] z_era;
  logic        z_excp_flush;
  logic        z_ertn_flush;
  logic [31:0] z_era_in;
  logic [5:0]  z_ecode_in;
  logic [8:0]  z_esubcode_in;
  logic        z_pipe_flush;
  logic        z_redir_valid;
  logic [31:0] z_redir_pc;
  logic        z_redir_ready;

  excp_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_excp(cmt_excp),
    .cmt_ertn(cmt_ertn), .cmt_ready(cmt_ready), .has_int(has_int),
    .eentry(eentry), .era(era),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush), .era_in(era_in),
    .ecode_in(ecode_in), .esubcode_in(esubcode_in), .pipe_flush(pipe_flush),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready)
  );

  excp_ctrl #(.DRAIN_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset),
    .cmt_valid(z_cmt_valid), .cmt_pc(z_cmt_pc), .cmt_excp(z_cmt_excp),
    .cmt_ertn(z_cmt_ertn), .cmt_ready(z_cmt_ready), .has_int(z_has_int),
    .eentry(z_eentry), .era(z_era),
    .excp_flush(z_excp_flush), .ertn_flush(z_ertn_flush), .era_in(z_era_in),
    .ecode_in(z_ecode_in), .esubcode_in(z_esubcode_in), .pipe_flush(z_pipe_flush),
    .redir_valid(z_redir_valid), .redir_pc(z_redir_pc), .redir_ready(z_redir_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          is_ertn;
    logic [31:0] era;
    logic [5:0]  ecode;
  } flush_t;

  flush_t      fq[$];
  logic [31:0] rq[$];

  int n_chk = 0;
  int n_err = 0;

  // Reference model state (cycle timeline)
  int cyc       = 0;
  bit in_flight = 1'b0;
  bit cur_ertn  = 1'b0;
  int flush_cyc = -100;
  int idle_from = 0;
  bit exp_ready = 1'b1;
  bit mon_en    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Trap selection from the cause priority list
  function automatic void classify(input bit hi, input logic [5:0] ex, input bit er,
                                   output bit take, output bit is_er, output logic [5:0] ec);
    logic [5:0] codes [6] = '{6'h08, 6'h0D, 6'h0E, 6'h0B, 6'h0C, 6'h09};
    take  = 1'b0;
    is_er = 1'b0;
    ec    = 6'h00;
    if (INT_EN && hi) begin
      take = 1'b1;
      return;
    end
    for (int i = 0; i < 6; i++) begin
      if (ex[i]) begin
        take = 1'b1;
        ec   = codes[i];
        return;
      end
    end
    if (er) begin
      take  = 1'b1;
      is_er = 1'b1;
    end
  endfunction

  // Drive one cycle of inputs and advance the reference timeline
  task automatic drive(input bit rst, input bit v, input logic [31:0] pc,
                       input logic [5:0] ex, input bit er, input bit hi,
                       input logic [31:0] ee, input logic [31:0] ea, input bit rr);
    bit         take;
    bit         is_er;
    logic [5:0] ec;
    flush_t     f;
    @(negedge clk);
    reset = rst; cmt_valid = v; cmt_pc = pc; cmt_excp = ex; cmt_ertn = er;
    has_int = hi; eentry = ee; era = ea; redir_ready = rr;
    if (rst) begin
      in_flight = 1'b0;
      flush_cyc = -100;
      idle_from = cyc + 1;
      mon_en    = 1'b1;
    end else if (!in_flight && cyc >= idle_from) begin
      if (v) begin
        classify(hi, ex, er, take, is_er, ec);
        if (take) begin
          f.is_ertn = is_er; f.era = pc; f.ecode = ec;
          fq.push_back(f);
          in_flight = 1'b1;
          cur_ertn  = is_er;
          flush_cyc = cyc + 1;
        end
      end
    end else if (in_flight && cyc == flush_cyc) begin
      rq.push_back(cur_ertn ? ea : ee);
    end else if (in_flight && cyc > flush_cyc && rr) begin
      in_flight = 1'b0;
      idle_from = cyc + int'(DRAIN) + 1;
    end
    exp_ready = !in_flight && (cyc + 1 >= idle_from);
    cyc++;
  endtask

  task automatic idle(input int n, input logic [31:0] ee, input logic [31:0] ea, input bit rr);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, ee, ea, rr);
  endtask

  // Monitor: checks the outputs of each cycle against the scoreboard
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc    = '0;
  initial begin
    flush_t      f;
    logic [31:0] rexp;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("cmt_ready", {31'h0, cmt_ready}, {31'h0, exp_ready});
        if (reset) begin
          // reset value here is the one sampled at the preceding edge
          chk("rst_redir_valid", {31'h0, redir_valid}, 32'h0);
          chk("rst_flushes", {29'h0, excp_flush, ertn_flush, pipe_flush}, 32'h0);
          chk("rst_redir_pc", redir_pc, 32'h0);
          chk("rst_era_in", era_in, 32'h0);
          chk("rst_codes", {17'h0, ecode_in, esubcode_in}, 32'h0);
        end else begin
          if (excp_flush || ertn_flush) begin
            chk("flush_expected", {31'h0, fq.size() > 0}, 32'h1);
            if (fq.size() > 0) begin
              f = fq.pop_front();
              chk("ertn_flush", {31'h0, ertn_flush}, {31'h0, f.is_ertn});
              chk("excp_flush", {31'h0, excp_flush}, {31'h0, !f.is_ertn});
              chk("era_in", era_in, f.era);
              if (!f.is_ertn) chk("ecode_in", {26'h0, ecode_in}, {26'h0, f.ecode});
              chk("esubcode_in", {23'h0, esubcode_in}, 32'h0);
              chk("pipe_flush_on", {31'h0, pipe_flush}, 32'h1);
            end
          end else begin
            chk("pipe_flush_off", {31'h0, pipe_flush}, 32'h0);
          end
          if (redir_valid && !prev_valid) begin
            chk("redir_expected", {31'h0, rq.size() > 0}, 32'h1);
            if (rq.size() > 0) begin
              rexp = rq.pop_front();
              chk("redir_pc", redir_pc, rexp);
            end
          end else if (redir_valid && prev_valid) begin
            chk("redir_pc_stable", redir_pc, prev_pc);
          end
          // redir_ready still holds the value of the cycle just ended
          if (prev_valid && !redir_valid)
            chk("redir_drop_without_ready", {31'h0, redir_ready}, 32'h1);
        end
        prev_valid = redir_valid;
        prev_pc    = redir_pc;
      end
    end
  end

  initial begin
    bit          v, er, hi, rr, rst;
    logic [5:0]  ex;
    logic [31:0] pc, ee, ea;
    bit          exp_rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bit          exp_fl  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bit          exp_rv  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; cmt_valid = 1'b0; cmt_pc = '0; cmt_excp = '0; cmt_ertn = 1'b0;
    has_int = 1'b0; eentry = '0; era = '0; redir_ready = 1'b0;
    z_cmt_valid = 1'b0; z_cmt_pc = 32'h1c000200; z_cmt_excp = '0; z_cmt_ertn = 1'b0;
    z_has_int = 1'b0; z_eentry = 32'h1c008000; z_era = '0; z_redir_ready = 1'b0;

    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(2, 32'h1c008000, 32'h1c000104, 1'b1);

    // SYS trap with fetch ready
    drive(1'b0, 1'b1, 32'h1c000100, 6'b001000, 1'b0, 1'b0, 32'h1c008000, 32'h1c000104, 1'b1);
    idle(6, 32'h1c008000, 32'h1c000104, 1'b1);
    // ERTN
    drive(1'b0, 1'b1, 32'h1c000300, 6'b000000, 1'b1, 1'b0, 32'h1c008000, 32'h1c000104, 1'b1);
    idle(6, 32'h1c008000, 32'h1c000104, 1'b1);
    // Interrupt together with INE|ALE
    drive(1'b0, 1'b1, 32'h1c000400, 6'b100010, 1'b0, 1'b1, 32'h1c008000, 32'h1c000104, 1'b1);
    idle(6, 32'h1c008000, 32'h1c000104, 1'b1);
    // Fetch stalls the redirect for 4 cycles
    drive(1'b0, 1'b1, 32'h1c000500, 6'b010000, 1'b0, 1'b0, 32'h1c008040, 32'h1c000104, 1'b0);
    idle(5, 32'h1c008040, 32'h1c000104, 1'b0);
    idle(6, 32'h1c008040, 32'h1c000104, 1'b1);
    // Reset while the redirect is pending
    drive(1'b0, 1'b1, 32'h1c000600, 6'b000001, 1'b0, 1'b0, 32'h1c008080, 32'h1c000104, 1'b0);
    idle(3, 32'h1c008080, 32'h1c000104, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 32'h1c008080, 32'h1c000104, 1'b0);
    idle(4, 32'h1c008080, 32'h1c000104, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      ex  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h0;
      er  = ($urandom_range(0, 4) == 0);
      hi  = ($urandom_range(0, 6) == 0);
      rr  = ($urandom_range(0, 1) == 1);
      pc  = $urandom;
      ee  = $urandom;
      ea  = $urandom;
      rst = in_flight && (cyc > flush_cyc) && ($urandom_range(0, 40) == 0);
      drive(rst, v, pc, ex, er, hi, ee, ea, rr);
    end
    idle(20, 32'h0, 32'h0, 1'b1);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    chk("flush_queue_empty", fq.size(), 32'h0);
    chk("redir_queue_empty", rq.size(), 32'h0);

    // DRAIN_CYCLES=0 instance: back-to-back BRK commits
    @(negedge clk);
    z_cmt_valid = 1'b1; z_cmt_excp = 6'b010000; z_redir_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("z_cmt_ready_%0d", k), {31'h0, z_cmt_ready}, {31'h0, exp_rdy[k]});
      chk($sformatf("z_excp_flush_%0d", k), {31'h0, z_excp_flush}, {31'h0, exp_fl[k]});
      chk($sformatf("z_redir_valid_%0d", k), {31'h0, z_redir_valid}, {31'h0, exp_rv[k]});
      if (exp_fl[k]) chk($sformatf("z_ecode_%0d", k), {26'h0, z_ecode_in}, 32'h0C);
      if (exp_rv[k]) chk($sformatf("z_redir_pc_%0d", k), z_redir_pc, 32'h1c008000);
      if (k == 4) z_cmt_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/excp_ctrl.md
# excp_ctrl

Exception/interrupt commit sequencer between the commit stage, the CSR file and fetch. It picks at most one trap event (interrupt, exception or ERTN) per committing instruction and drives the CSR's `excp_flush` / `ertn_flush`, `era_in`, `ecode_in` and `esubcode_in`. It then flushes the pipeline and hands a redirect PC to fetch over a valid/ready handshake. Commit is serialised while a trap is in flight.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 2: cycles commit stays blocked after the redirect handshake, range 0..15.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `cmt_valid` in 1: commit-stage instruction valid.
- `cmt_pc` in 32: PC of the committing instruction.
- `cmt_excp` in 6: exception flags, one bit per cause:
  - [0] ADEF
  - [1] INE
  - [2] IPE
  - [3] SYS
  - [4] BRK
  - [5] ALE
- `cmt_ertn` in 1: committing instruction is ERTN.
- `cmt_ready` out 1: controller accepts a commit this cycle.
- `has_int` in 1: pending, enabled interrupt from the CSR file.
- `eentry` in 32: CSR EENTRY.
- `era` in 32: CSR ERA.
- `excp_flush` out 1: one-cycle trap-entry pulse to the CSR file.
- `ertn_flush` out 1: one-cycle trap-return pulse to the CSR file.
- `era_in` out 32: ERA value for the CSR.
- `ecode_in` out 6: Ecode for the CSR.
- `esubcode_in` out 9: EsubCode for the CSR.
- `pipe_flush` out 1: kill all younger in-flight instructions.
- `redir_valid` out 1: redirect request to fetch.
- `redir_pc` out 32: redirect target.
- `redir_ready` in 1: fetch accepts the redirect.

## Operation
- FSM states: IDLE, FLUSH, REDIR, DRAIN. Reset puts the FSM in IDLE.
- Reset values: every output is 0 except `cmt_ready`, which is 1.
- `cmt_ready` = (state == IDLE). Commits without a trap event pass through IDLE with no action.
- Event detection in IDLE: `cmt_valid` && (`has_int` || |`cmt_excp` || `cmt_ertn`).
- On detection, latch the following and go to FLUSH:
  - trap kind (excp or ertn);
  - `era_in` = `cmt_pc`;
  - `ecode_in` and `esubcode_in` from the priority encoder.
- Priority, highest first: INT > ADEF > INE > IPE > SYS > BRK > ALE > ERTN.
  - An exception on an ERTN instruction is taken as the exception; no `ertn_flush` is issued.
  - An interrupt pre-empts the committing instruction; ERA is that instruction's PC.
- Ecode values (hex):
  - INT 00
  - ADEF 08
  - ALE 09
  - SYS 0B
  - BRK 0C
  - INE 0D
  - IPE 0E
  - `esubcode_in` is 0 for all causes.
- FLUSH (one cycle):
  - Assert `pipe_flush` and exactly one of `excp_flush` / `ertn_flush`.
  - Latch `redir_pc` = `eentry` for a trap, or `era` for ERTN.
  - Go to REDIR.
- REDIR:
  - `redir_valid` = 1; `redir_pc` is held stable until `redir_ready`.
  - When the handshake completes, go to DRAIN with the counter loaded to `DRAIN_CYCLES`, or go to IDLE directly if `DRAIN_CYCLES` == 0.
- DRAIN: decrement the counter; return to IDLE when it reaches 1.
- `era_in`, `ecode_in` and `esubcode_in` hold their last latched values outside FLUSH. The CSR only samples them while `excp_flush` is high.
- Reset asserted in any state: next cycle is IDLE with all outputs at reset values. No partial flush pulse is emitted.

## Timing
- Event accepted at cycle T (IDLE, `cmt_ready` high).
- T+1: FLUSH; `excp_flush`/`ertn_flush` and `pipe_flush` high for this cycle only.
- T+2: REDIR. Earliest handshake is at T+2 if `redir_ready` is already high.
- Handshake at cycle H: DRAIN occupies H+1 .. H+`DRAIN_CYCLES`, and IDLE is reached at H+`DRAIN_CYCLES`+1.
  - Minimum turnaround with `DRAIN_CYCLES`=2: IDLE again at T+5.
- `redir_valid` never drops before `redir_ready`. A `redir_ready` that arrives outside REDIR is ignored.
- `has_int` and `cmt_*` are sampled only in IDLE. Changes in any other state are ignored.

## Configuration
- Macro `EXCP_CTRL_INT_EN`.
- Defined: `has_int` participates in event detection as above.
- Undefined:
  - `has_int` is ignored and the INT ecode is never produced.
  - Only instruction exceptions and ERTN start the sequence.
  - The port stays present but unused.

## Structure
- Shared package `excp_pkg` holds:
  - the state enum;
  - Ecode constants (ECODE_INT, ECODE_ADEF, ECODE_ALE, ECODE_SYS, ECODE_BRK, ECODE_INE, ECODE_IPE);
  - `cmt_excp` bit-index constants.
- One sub-module, `excp_prio_enc`: purely combinational. It takes `has_int`, `cmt_excp` and `cmt_ertn`, and produces `take`, `is_ertn`, `ecode` and `esubcode`. The FSM, counter and latches stay in `excp_ctrl`.

## Test plan
- SYS at `cmt_pc`=0x1c000100, `eentry`=0x1c008000, `redir_ready`=1:
  - T+1: `excp_flush`=1, `ecode_in`=0x0B, `era_in`=0x1c000100.
  - T+2: `redir_valid`=1 with `redir_pc`=0x1c008000.
  - T+5: `cmt_ready`=1.
- ERTN with `era`=0x1c000104: `ertn_flush` pulses for one cycle, `excp_flush` stays 0, `redir_pc`=0x1c000104.
- `has_int`=1 together with `cmt_excp`=INE|ALE on the same commit: `ecode_in`=0x00; with `EXCP_CTRL_INT_EN` undefined, `ecode_in`=0x0D.
- `redir_ready` held low for 4 cycles in REDIR:
  - `redir_valid` and `redir_pc` stay stable throughout;
  - `cmt_ready`=0 throughout;
  - DRAIN starts the cycle after `redir_ready` rises.
- `reset` pulsed during REDIR: next cycle is IDLE, `redir_valid`=0, `cmt_ready`=1, and no flush pulses occur.
- `DRAIN_CYCLES`=0 with back-to-back BRK commits:
  - second event accepted the cycle after the first handshake;
  - `ecode_in`=0x0C on both.
